// File: rtl/y86_io_ctrl.sv
// Keyboard read/clear sequencer feeding an RX FIFO, plus a TTY writer that arbitrates
// CPU transmit against keyboard echo round-robin, with screen clear at top priority.
module y86_io_ctrl #(
  parameter  int RX_DEPTH = 4,
  parameter  int CW       = 7,
  localparam int PW       = $clog2(RX_DEPTH),
  localparam int NW       = PW + 1
) (
  input  logic          mclk,
  input  logic          reset,
  input  logic          KB_status,
  input  logic [CW-1:0] KB_data,
  output logic          KB_read_en,
  output logic          KB_clear,
  input  logic          TTY_ready,
  output logic [CW-1:0] TTY_data,
  output logic          TTY_en,
  output logic          TTY_clear,
  input  logic          echo_en,
  output logic          cpu_rx_valid,
  output logic [CW-1:0] cpu_rx_data,
  input  logic          cpu_rx_pop,
  input  logic          cpu_tx_valid,
  input  logic [CW-1:0] cpu_tx_data,
  output logic          cpu_tx_ready,
  input  logic          cpu_clr_req,
  output logic [NW-1:0] rx_count
);
  typedef enum logic [1:0] {KB_IDLE, KB_READ, KB_CAPT, KB_CLR} kb_state_e;
  typedef enum logic [1:0] {T_IDLE, T_WRITE, T_CLEAR, T_GUARD} tty_state_e;
  localparam logic SRC_HOLD = 1'b0;
  localparam logic SRC_ECHO = 1'b1;

  kb_state_e     kb_state_q, kb_state_d;
  tty_state_e    tty_state_q, tty_state_d;
  logic [CW-1:0] rx_mem [RX_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [NW-1:0] count_q, count_d;
  logic          hold_full_q, hold_full_d, echo_full_q, echo_full_d;
  logic [CW-1:0] hold_data_q, hold_data_d, echo_data_q, echo_data_d;
  logic [CW-1:0] tty_data_q, tty_data_d;
  logic          tx_ready_q, tx_ready_d, clr_pend_q, clr_pend_d;
  logic          last_q, last_d, sel_q, sel_d;
  logic          rx_full, push, pop, grant_src, tty_start;

  assign rx_full   = (count_q == NW'(RX_DEPTH));
  assign push      = (kb_state_q == KB_CAPT);
  assign pop       = cpu_rx_pop && (count_q != '0);
  assign tty_start = (tty_state_q == T_IDLE) && (tty_state_d == T_WRITE);

  // Tie goes to whichever source was not granted last; reset leaves last=echo.
  always_comb begin
    if (hold_full_q && echo_full_q) grant_src = ~last_q;
    else                            grant_src = echo_full_q ? SRC_ECHO : SRC_HOLD;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      kb_state_q  <= KB_IDLE;
      tty_state_q <= T_IDLE;
    end else begin
      kb_state_q  <= kb_state_d;
      tty_state_q <= tty_state_d;
    end
  end

  always_comb begin
    kb_state_d = kb_state_q;
    case (kb_state_q)
      KB_IDLE: if (KB_status && !rx_full && (!echo_en || !echo_full_q)) kb_state_d = KB_READ;
      KB_READ: kb_state_d = KB_CAPT;
      KB_CAPT: kb_state_d = KB_CLR;
      KB_CLR:  kb_state_d = KB_IDLE;
      default: kb_state_d = KB_IDLE;
    endcase
  end

  always_comb begin
    tty_state_d = tty_state_q;
    case (tty_state_q)
      T_IDLE: begin
        if (TTY_ready) begin
          if (clr_pend_q)                      tty_state_d = T_CLEAR;
          else if (hold_full_q || echo_full_q) tty_state_d = T_WRITE;
        end
      end
      T_WRITE: tty_state_d = T_IDLE;
      T_CLEAR: tty_state_d = T_GUARD;
      T_GUARD: tty_state_d = T_IDLE;
      default: tty_state_d = T_IDLE;
    endcase
  end

  always_comb begin
    KB_read_en = (kb_state_q == KB_READ);
    KB_clear   = (kb_state_q == KB_CLR);
    TTY_en     = (tty_state_q == T_WRITE);
    TTY_clear  = (tty_state_q == T_CLEAR);
  end

  always_comb begin
    wr_ptr_d    = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d    = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d     = count_q;
    if (push && !pop)      count_d = count_q + NW'(1);
    else if (pop && !push) count_d = count_q - NW'(1);

    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    echo_full_d = echo_full_q;
    echo_data_d = echo_data_q;
    if (TTY_en && sel_q == SRC_HOLD) hold_full_d = 1'b0;
    if (TTY_en && sel_q == SRC_ECHO) echo_full_d = 1'b0;
    if (cpu_tx_valid && tx_ready_q) begin
      hold_full_d = 1'b1;
      hold_data_d = cpu_tx_data;
    end
    // A queued echo is never overwritten, even if echo_en toggled mid-read.
    if (push && echo_en && !echo_full_d) begin
      echo_full_d = 1'b1;
      echo_data_d = KB_data;
    end
    tx_ready_d  = ~hold_full_d;

    clr_pend_d  = (clr_pend_q && !TTY_clear) || cpu_clr_req;
    last_d      = TTY_en ? sel_q : last_q;
    sel_d       = tty_start ? grant_src : sel_q;
    tty_data_d  = tty_data_q;
    if (tty_start) tty_data_d = (grant_src == SRC_ECHO) ? echo_data_q : hold_data_q;
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      echo_full_q <= 1'b0;
      echo_data_q <= '0;
      tx_ready_q  <= 1'b0;
      clr_pend_q  <= 1'b0;
      last_q      <= SRC_ECHO;
      sel_q       <= SRC_HOLD;
      tty_data_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      echo_full_q <= echo_full_d;
      echo_data_q <= echo_data_d;
      tx_ready_q  <= tx_ready_d;
      clr_pend_q  <= clr_pend_d;
      last_q      <= last_d;
      sel_q       <= sel_d;
      tty_data_q  <= tty_data_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (push) rx_mem[wr_ptr_q] <= KB_data;
  end

  assign cpu_rx_valid = (count_q != '0);
  assign cpu_rx_data  = cpu_rx_valid ? rx_mem[rd_ptr_q] : '0;
  assign rx_count     = count_q;
  assign TTY_data     = tty_data_q;
  assign cpu_tx_ready = tx_ready_q;
endmodule
